// File: rtl/alu_rs_pkg.sv
//==============================================================================
// Module      : alu_rs_pkg
// Description : Shared constants for the ALU reservation station: ROB/RS
//               sizing, RV32I opcodes and the packed op encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_rs_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int ROB_W_DEF   = 4;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_RI    = 7'b0010011;
    localparam logic [6:0] OP_RR    = 7'b0110011;

    // {funct7[5], funct3, opcode}
    typedef logic [10:0] alu_op_t;

    function automatic alu_op_t mk_op(input logic f7b5, input logic [2:0] f3,
                                      input logic [6:0] opc);
        return {f7b5, f3, opc};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rs_pick.sv
//==============================================================================
// Module      : rs_pick
// Description : Lowest-index priority encoder returning a found flag and index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rs_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = i[IW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
//==============================================================================
// Module      : alu_rs
// Description : ALU reservation station: buffers dispatched ALU-class ops,
//               snoops both CDBs, issues the lowest ready entry per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             in_valid,
    input  alu_op_t          in_op,
    input  logic             in_q1_valid,
    input  logic [ROB_W-1:0] in_q1,
    input  logic [31:0]      in_v1,
    input  logic             in_q2_valid,
    input  logic [ROB_W-1:0] in_q2,
    input  logic [31:0]      in_v2,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [ROB_W-1:0] in_rob_id,
    output logic             full_out,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_rob,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_rob,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_yes,
    output alu_op_t          alu_op,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2,
    output logic [31:0]      alu_pc,
    output logic [31:0]      alu_imm,
    output logic [ROB_W-1:0] alu_rob_id
);

    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_q1v;
    logic [RS_SIZE-1:0] r_q2v;
    alu_op_t            r_op  [RS_SIZE];
    logic [ROB_W-1:0]   r_q1  [RS_SIZE];
    logic [ROB_W-1:0]   r_q2  [RS_SIZE];
    logic [31:0]        r_v1  [RS_SIZE];
    logic [31:0]        r_v2  [RS_SIZE];
    logic [31:0]        r_pc  [RS_SIZE];
    logic [31:0]        r_imm [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];

    logic               w_free_found;
    logic [IW-1:0]      w_free_idx;
    logic               w_rdy_found;
    logic [IW-1:0]      w_rdy_idx;
    logic               w_in_q1v;
    logic               w_in_q2v;
    logic [31:0]        w_in_v1;
    logic [31:0]        w_in_v2;

    assign full_out = &r_busy;

    rs_pick #(.N(RS_SIZE), .IW(IW)) u_pick_free (
        .req   (~r_busy),
        .found (w_free_found),
        .idx   (w_free_idx)
    );

    rs_pick #(.N(RS_SIZE), .IW(IW)) u_pick_rdy (
        .req   (r_busy & ~r_q1v & ~r_q2v),
        .found (w_rdy_found),
        .idx   (w_rdy_idx)
    );

    // Same-cycle forwarding for operands whose producer broadcasts right now.
    always_comb begin
        w_in_q1v = in_q1_valid;
        w_in_v1  = in_v1;
        w_in_q2v = in_q2_valid;
        w_in_v2  = in_v2;
        if (in_q1_valid && cdb_alu_valid && cdb_alu_rob == in_q1) begin
            w_in_q1v = 1'b0;
            w_in_v1  = cdb_alu_value;
        end else if (in_q1_valid && cdb_lsb_valid && cdb_lsb_rob == in_q1) begin
            w_in_q1v = 1'b0;
            w_in_v1  = cdb_lsb_value;
        end
        if (in_q2_valid && cdb_alu_valid && cdb_alu_rob == in_q2) begin
            w_in_q2v = 1'b0;
            w_in_v2  = cdb_alu_value;
        end else if (in_q2_valid && cdb_lsb_valid && cdb_lsb_rob == in_q2) begin
            w_in_q2v = 1'b0;
            w_in_v2  = cdb_lsb_value;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy     <= '0;
            r_q1v      <= '0;
            r_q2v      <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_q1[i]  <= '0;
                r_q2[i]  <= '0;
                r_v1[i]  <= '0;
                r_v2[i]  <= '0;
                r_pc[i]  <= '0;
                r_imm[i] <= '0;
                r_rob[i] <= '0;
            end
            alu_yes    <= 1'b0;
            alu_op     <= '0;
            alu_v1     <= '0;
            alu_v2     <= '0;
            alu_pc     <= '0;
            alu_imm    <= '0;
            alu_rob_id <= '0;
        end else if (clear_in) begin
            r_busy  <= '0;
            alu_yes <= 1'b0;
        end else if (!rdy_in) begin
            alu_yes <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_q1v[i]) begin
                    if (cdb_alu_valid && cdb_alu_rob == r_q1[i]) begin
                        r_v1[i]  <= cdb_alu_value;
                        r_q1v[i] <= 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_rob == r_q1[i]) begin
                        r_v1[i]  <= cdb_lsb_value;
                        r_q1v[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_q2v[i]) begin
                    if (cdb_alu_valid && cdb_alu_rob == r_q2[i]) begin
                        r_v2[i]  <= cdb_alu_value;
                        r_q2v[i] <= 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_rob == r_q2[i]) begin
                        r_v2[i]  <= cdb_lsb_value;
                        r_q2v[i] <= 1'b0;
                    end
                end
            end

            alu_yes <= w_rdy_found;
            if (w_rdy_found) begin
                alu_op            <= r_op[w_rdy_idx];
                alu_v1            <= r_v1[w_rdy_idx];
                alu_v2            <= r_v2[w_rdy_idx];
                alu_pc            <= r_pc[w_rdy_idx];
                alu_imm           <= r_imm[w_rdy_idx];
                alu_rob_id        <= r_rob[w_rdy_idx];
                r_busy[w_rdy_idx] <= 1'b0;
            end

            // The free slot is never the issuing one, so these writes are disjoint.
            if (in_valid && w_free_found) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= in_op;
                r_q1v[w_free_idx]  <= w_in_q1v;
                r_q1[w_free_idx]   <= in_q1;
                r_v1[w_free_idx]   <= w_in_v1;
                r_q2v[w_free_idx]  <= w_in_q2v;
                r_q2[w_free_idx]   <= in_q2;
                r_v2[w_free_idx]   <= w_in_v2;
                r_pc[w_free_idx]   <= in_pc;
                r_imm[w_free_idx]  <= in_imm;
                r_rob[w_free_idx]  <= in_rob_id;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
//==============================================================================
// Module      : tb_alu_rs
// Description : Directed self-checking bench for the ALU reservation station.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        in_valid, in_q1_valid, in_q2_valid;
    alu_op_t     in_op;
    logic [3:0]  in_q1, in_q2, in_rob_id;
    logic [31:0] in_v1, in_v2, in_pc, in_imm;
    logic        full_out;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        alu_yes;
    alu_op_t     alu_op;
    logic [31:0] alu_v1, alu_v2, alu_pc, alu_imm;
    logic [3:0]  alu_rob_id;

    int vectors    = 0;
    int miscompares = 0;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_valid(in_valid), .in_op(in_op),
        .in_q1_valid(in_q1_valid), .in_q1(in_q1), .in_v1(in_v1),
        .in_q2_valid(in_q2_valid), .in_q2(in_q2), .in_v2(in_v2),
        .in_pc(in_pc), .in_imm(in_imm), .in_rob_id(in_rob_id),
        .full_out(full_out),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_value(cdb_lsb_value),
        .alu_yes(alu_yes), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dispatch(input logic q1v, input logic [3:0] q1, input logic [31:0] v1,
                            input logic q2v, input logic [3:0] q2, input logic [31:0] v2,
                            input logic [31:0] pc, input logic [3:0] rob);
        in_valid    = 1'b1;
        in_op       = mk_op(1'b0, 3'b000, OP_RR);
        in_q1_valid = q1v; in_q1 = q1; in_v1 = v1;
        in_q2_valid = q2v; in_q2 = q2; in_v2 = v2;
        in_pc       = pc;
        in_imm      = 32'h0;
        in_rob_id   = rob;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_q1_valid   = 1'b0;
        in_q2_valid   = 1'b0;
        cdb_alu_valid = 1'b0;
        cdb_lsb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        in_op = '0; in_q1 = '0; in_q2 = '0; in_v1 = '0; in_v2 = '0;
        in_pc = '0; in_imm = '0; in_rob_id = '0;
        cdb_alu_rob = '0; cdb_lsb_rob = '0; cdb_alu_value = '0; cdb_lsb_value = '0;
        idle();
        tick(); tick();
        vectors++;
        if (alu_yes !== 1'b0 || full_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: alu_yes=%b full_out=%b, want 0/0", alu_yes, full_out);
        end
        vectors++;
        if (alu_v1 !== 32'h0 || alu_pc !== 32'h0 || alu_rob_id !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: v1=%h pc=%h rob=%h, want zeros", alu_v1, alu_pc, alu_rob_id);
        end
        @(negedge clk_in); rst_in = 1'b1;
        tick();
    endtask

    task automatic test_ready_issue();
        dispatch(1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'h1000, 4'd3);
        tick();
        idle();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_same_cycle: alu_yes=%b, want 0", alu_yes);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_v1 !== 32'd5 || alu_v2 !== 32'd7 || alu_rob_id !== 4'd3
            || alu_op !== 11'h033 || alu_pc !== 32'h1000) begin
            miscompares++;
            $display("FAIL ready_issue: yes=%b v1=%0d v2=%0d rob=%0d op=%h pc=%h, want 1/5/7/3/033/1000",
                     alu_yes, alu_v1, alu_v2, alu_rob_id, alu_op, alu_pc);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_drop: alu_yes=%b, want 0", alu_yes);
        end
    endtask

    task automatic test_cdb_wakeup();
        dispatch(1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd0, 32'd3, 32'h2000, 4'd4);
        tick();
        idle();
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_early: alu_yes=%b, want 0", alu_yes);
        end
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd2; cdb_lsb_value = 32'h100;
        tick();
        idle();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_bcast_cycle: alu_yes=%b, want 0", alu_yes);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_v1 !== 32'h100 || alu_v2 !== 32'd3 || alu_rob_id !== 4'd4) begin
            miscompares++;
            $display("FAIL wakeup_issue: yes=%b v1=%h v2=%0d rob=%0d, want 1/100/3/4",
                     alu_yes, alu_v1, alu_v2, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_dispatch_forward();
        dispatch(1'b0, 4'd0, 32'd1, 1'b1, 4'd5, 32'hBAD, 32'h3000, 4'd6);
        cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd5; cdb_alu_value = 32'd9;
        tick();
        idle();
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_v2 !== 32'd9 || alu_v1 !== 32'd1 || alu_rob_id !== 4'd6) begin
            miscompares++;
            $display("FAIL forward_issue: yes=%b v1=%0d v2=%0d rob=%0d, want 1/1/9/6",
                     alu_yes, alu_v1, alu_v2, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_fill_and_drain();
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'(i), 32'h4000 + 32'(i), 4'(i + 8));
            tick();
        end
        idle();
        vectors++;
        if (full_out !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: full_out=%b, want 1", full_out);
        end
        // Dispatch while full must be dropped.
        dispatch(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'hDEAD, 4'd1);
        tick();
        idle();
        cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd7; cdb_alu_value = 32'h77;
        tick();
        idle();
        vectors++;
        if (alu_yes !== 1'b0 || full_out !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_latch: yes=%b full=%b, want 0/1", alu_yes, full_out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (alu_yes !== 1'b1 || alu_pc !== 32'h4000 + 32'(k) || alu_v1 !== 32'h77
                || alu_rob_id !== 4'(k + 8)) begin
                miscompares++;
                $display("FAIL drain_%0d: yes=%b pc=%h v1=%h rob=%0d, want 1/%h/77/%0d",
                         k, alu_yes, alu_pc, alu_v1, alu_rob_id, 32'h4000 + 32'(k), k + 8);
            end
            if (k == 0) begin
                vectors++;
                if (full_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drain_full_drop: full_out=%b, want 0", full_out);
                end
            end
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_end: alu_yes=%b pc=%h, want 0", alu_yes, alu_pc);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            dispatch(1'b1, 4'd6, 32'h0, 1'b0, 4'd0, 32'h0, 32'h5000 + 32'(i), 4'(i));
            tick();
        end
        idle();
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd6; cdb_lsb_value = 32'h66;
        tick();
        idle();
        clear_in = 1'b1;
        dispatch(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'hBEEF, 4'd9);
        tick();
        clear_in = 1'b0;
        idle();
        vectors++;
        if (alu_yes !== 1'b0 || full_out !== 1'b0 || dut.r_busy !== 8'h00) begin
            miscompares++;
            $display("FAIL clear_flush: yes=%b full=%b busy=%b, want 0/0/00000000",
                     alu_yes, full_out, dut.r_busy);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_no_issue: alu_yes=%b, want 0", alu_yes);
        end
        dispatch(1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd12, 32'h5500, 4'd0);
        tick();
        idle();
        vectors++;
        if (dut.r_busy !== 8'h01) begin
            miscompares++;
            $display("FAIL clear_slot0: busy=%b, want 00000001", dut.r_busy);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_pc !== 32'h5500 || alu_rob_id !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_reissue: yes=%b pc=%h rob=%0d, want 1/5500/0", alu_yes, alu_pc, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_async_reset_and_stall();
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h0, 32'h6000 + 32'(i), 4'(i));
            tick();
        end
        idle();
        cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd9; cdb_alu_value = 32'h99;
        tick();
        idle();
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_pc !== 32'h6000) begin
            miscompares++;
            $display("FAIL pre_reset_issue: yes=%b pc=%h, want 1/6000", alu_yes, alu_pc);
        end
        #2 rst_in = 1'b0;
        #1;
        vectors++;
        if (alu_yes !== 1'b0 || full_out !== 1'b0 || dut.r_busy !== 8'h00 || alu_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: yes=%b full=%b busy=%b pc=%h, want 0/0/00000000/0",
                     alu_yes, full_out, dut.r_busy, alu_pc);
        end
        tick();
        @(negedge clk_in); rst_in = 1'b1;
        tick();

        dispatch(1'b1, 4'd4, 32'h0, 1'b0, 4'd0, 32'h1, 32'h7000, 4'd2);
        tick();
        idle();
        rdy_in = 1'b0;
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd4; cdb_lsb_value = 32'h44;
        tick();
        idle();
        rdy_in = 1'b1;
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_1: alu_yes=%b, want 0", alu_yes);
        end
        tick();
        vectors++;
        if (alu_yes !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_2: alu_yes=%b, want 0", alu_yes);
        end
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd4; cdb_lsb_value = 32'h55;
        tick();
        idle();
        tick();
        vectors++;
        if (alu_yes !== 1'b1 || alu_v1 !== 32'h55 || alu_pc !== 32'h7000) begin
            miscompares++;
            $display("FAIL stall_resume: yes=%b v1=%h pc=%h, want 1/55/7000", alu_yes, alu_v1, alu_pc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_cdb_wakeup();
        test_dispatch_forward();
        test_fill_and_drain();
        test_clear();
        test_async_reset_and_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that feeds the integer ALU; it is the initiator side of the ALU issue interface (yes/op/v1/v2/pc/imm/rob_id).
- Buffers dispatched ALU-class instructions (lui, auipc, jal, jalr, branch, reg-imm, reg-reg).
- Snoops both CDB buses (ALU result loop-back and LSB result) to resolve pending operands.
- Each cycle, issues at most one ready entry to the ALU with registered outputs.

Parameters:
- RS_SIZE, 8, number of entries (power of 2).
- ROB_W, 4, ROB tag width; matches the width of the shared ROB-range macro.

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low = hold all state
- clear_in  in  1  misprediction flush
- in_valid  in  1  dispatch strobe
- in_op  in  11  {funct7[5], funct3, opcode}
- in_q1_valid  in  1  operand 1 pending
- in_q1  in  ROB_W  operand 1 producer tag
- in_v1  in  32  operand 1 value, when not pending
- in_q2_valid, in_q2, in_v2  in  1/ROB_W/32  same fields for operand 2
- in_pc  in  32  instruction PC
- in_imm  in  32  immediate
- in_rob_id  in  ROB_W  destination tag
- full_out  out  1  no free entry
- cdb_alu_valid, cdb_alu_rob, cdb_alu_value  in  1/ROB_W/32  ALU broadcast
- cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_value  in  1/ROB_W/32  LSB broadcast
- alu_yes  out  1  issue strobe
- alu_op  out  11  issued op
- alu_v1, alu_v2, alu_pc, alu_imm  out  32  issued operands
- alu_rob_id  out  ROB_W  issued tag

Behaviour:
- Reset (rst_in=0, async): all busy bits 0; alu_yes=0; alu_* data outputs 0; full_out=0.
- Entry state: busy, op, q1_valid/q1/v1, q2_valid/q2/v2, pc, imm, rob_id.
- full_out is combinational: 1 iff all busy bits are 1, evaluated on state at cycle start. The dispatcher must not assert in_valid while full_out=1; if it does, the dispatch is dropped.
- Dispatch: in_valid writes into the lowest-index free entry, using busy state at cycle start.
  - A slot freed by an issue in the same cycle is reusable next cycle only.
- Same-cycle forwarding at dispatch: if in_qX_valid and a CDB bus this cycle carries tag in_qX, store the bus value and clear qX_valid.
- CDB snoop, every cycle, every busy entry: on a tag match with qX_valid=1, latch the value and clear qX_valid.
  - If both buses match the same tag, the ALU bus wins. ROB tag uniqueness makes this illegal in practice.
- Ready = busy & !q1_valid & !q2_valid, from registered state only. An operand arriving on the CDB in cycle N makes the entry issuable in cycle N+1.
- Issue selection: the lowest-index ready entry.
  - At the edge: alu_yes<=1, alu_* <= entry fields, entry busy<=0.
  - With no ready entry, alu_yes<=0 and data outputs hold their values.
- Latency: dispatch of fully ready operands accepted at edge E gives alu_yes=1 after edge E+1; the ALU result appears after E+2.
- A newly dispatched entry never issues in the same cycle it is written.
- Entries not referencing a broadcast tag are unaffected by it. Tag 0 is an ordinary tag; validity comes from qX_valid only.
- clear_in=1 (highest priority after reset):
  - all busy<=0 and alu_yes<=0 at the edge;
  - in_valid and CDB that cycle are ignored;
  - full_out=0 next cycle.
- rdy_in=0 (and clear_in=0): entry state frozen, no dispatch accepted, no CDB latch, alu_yes<=0. The upstream stalls in lockstep, so nothing is lost.
- Reset asserted mid-operation: immediate clear regardless of clock; first possible issue is 2 edges after release plus a dispatch.

Decomposition:
- Shared const.v defines:
  - the ROB tag range macro;
  - opcode macros (olui, oauipc, ojal, ojalr, ob, ori, orr);
  - RS size define.
- Sub-module rs_pick: parameterised lowest-index priority encoder, returning a found flag and an index. It is instantiated twice, once for the free-slot search and once for the ready-entry search.

Test Plan:
- Dispatch add (op orr/000), v1=5, v2=7, rob 3, both ready at edge E -> after E+1: alu_yes=1, alu_v1=5, alu_v2=7, alu_rob_id=3; alu_yes=0 after E+2.
- Dispatch with q1=rob 2 pending; 2 cycles later cdb_lsb rob 2 value 0x100 -> issue one cycle after the broadcast with alu_v1=0x100; no issue earlier.
- Dispatch with q2=rob 5 while cdb_alu carries rob 5 value 9 in the same cycle -> issues as if ready, alu_v2=9, latency identical to the fully-ready case.
- Fill 8 entries all waiting on rob 7 -> full_out=1.
  - Broadcast rob 7 -> entries 0..7 issue on 8 consecutive cycles in index order.
  - full_out drops one cycle after the first issue.
- 3 ready entries, assert clear_in for 1 cycle -> alu_yes=0 next cycle, full_out=0, no further issue; a new dispatch afterwards lands in entry 0.
- Pull rst_in low between clock edges with entries busy -> alu_yes=0 immediately, full_out=0; hold rdy_in=0 across a CDB broadcast -> the entry stays pending.
